// File: rtl/reg_file_param_if.sv
// Register-file access bundle: decode-side reads, writeback-side write,
// and the bulk-clear handshake.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   R_Addr_A;
  logic [ADDR_W-1:0]   R_Addr_B;
  logic [DATA_W-1:0]   R_Data_A;
  logic [DATA_W-1:0]   R_Data_B;
  logic [ADDR_W-1:0]   W_Addr;
  logic [DATA_W-1:0]   W_Data;
  logic [DATA_W/8-1:0] W_Be;
  logic                Write_Reg;
  logic                Clr_Req;
  logic                Clr_Busy;
  logic                Clr_Done;
  logic                Wr_Drop;

  modport master (
    output R_Addr_A, R_Addr_B,
    output W_Addr, W_Data, W_Be,
    output Write_Reg, Clr_Req,
    input  R_Data_A, R_Data_B,
    input  Clr_Busy, Clr_Done, Wr_Drop
  );

  modport slave (
    input  R_Addr_A, R_Addr_B,
    input  W_Addr, W_Data, W_Be,
    input  Write_Reg, Clr_Req,
    output R_Data_A, R_Data_B,
    output Clr_Busy, Clr_Done, Wr_Drop
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised GPR file: 2 async reads, 1 byte-enabled write,
// optional zero register and bypass, sequential bulk-clear engine.
module reg_file_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input logic               clk,
  input logic               Reset,
  reg_file_param_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;
  localparam logic [ADDR_W:0] LAST =
    (ADDR_W+1)'(DEPTH-1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W:0]   ptr_d;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] wr_data_d;
  logic              wr_ok;
  logic              w_zero;

  assign w_zero = (ZERO_R0 != 0) &&
                  (bus.W_Addr == '0);
  assign wr_ok  = bus.Write_Reg & ~busy_q &
                  ~Reset & ~w_zero;
  assign ptr_d  = ptr_q + 1'b1;

  // Byte-merge of the addressed entry with the incoming write
  for (genvar i = 0; i < NB; i++) begin : g_be
    assign wr_data_d[8*i +: 8] = bus.W_Be[i]
      ? bus.W_Data[8*i +: 8]
      : mem_q[bus.W_Addr][8*i +: 8];
  end

  always_comb begin
    bus.R_Data_A = mem_q[bus.R_Addr_A];
    if (BYPASS != 0 && wr_ok &&
        bus.R_Addr_A == bus.W_Addr)
      bus.R_Data_A = wr_data_d;
    if (ZERO_R0 != 0 && bus.R_Addr_A == '0)
      bus.R_Data_A = '0;
  end

  always_comb begin
    bus.R_Data_B = mem_q[bus.R_Addr_B];
    if (BYPASS != 0 && wr_ok &&
        bus.R_Addr_B == bus.W_Addr)
      bus.R_Data_B = wr_data_d;
    if (ZERO_R0 != 0 && bus.R_Addr_B == '0)
      bus.R_Data_B = '0;
  end

  assign bus.Clr_Busy = busy_q;
  assign bus.Clr_Done = done_q;
  assign bus.Wr_Drop  = bus.Write_Reg & busy_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (wr_ok)
        mem_q[bus.W_Addr] <= wr_data_d;
      unique case (state_q)
        IDLE: begin
          if (bus.Clr_Req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          mem_q[ptr_q[ADDR_W-1:0]] <= '0;
          ptr_q <= ptr_d;
          if (ptr_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
